// File: rtl/charram_dram_ctrl.sv
// charram_dram_ctrl: arbitrates video fetch and CPU access onto a 4416-style 16k x 4 DRAM.
// It sequences RAS/CAS/RD/WR for each access. Define CHARRAM_DRAM_REFRESH_EN to add periodic RAS-only refresh.
module charram_dram_ctrl #(
    parameter int REFRESH_INTERVAL = 64
) (
    input  logic        i_MCLK,
    input  logic        i_RST_n,
    input  logic        i_CEN,
    input  logic        i_VID_REQ,
    input  logic [13:0] i_VID_ADDR,
    output logic [3:0]  o_VID_DATA,
    output logic        o_VID_VALID,
    input  logic        i_CPU_CS_n,
    input  logic        i_CPU_RW,
    input  logic [13:0] i_CPU_ADDR,
    input  logic [3:0]  i_CPU_DIN,
    output logic [3:0]  o_CPU_DOUT,
    output logic        o_DTACK_n,
    output logic [7:0]  o_ADDR,
    output logic        o_RAS_n,
    output logic        o_CAS_n,
    output logic        o_WR_n,
    output logic        o_RD_n,
    output logic [3:0]  o_DRAM_DIN,
    input  logic [3:0]  i_DRAM_DOUT
);
    typedef enum logic [2:0] {S_IDLE, S_ROW, S_COL, S_DATA, S_LATCH, S_PRE} state_t;
    typedef enum logic [1:0] {K_VID, K_CPU, K_REF} kind_t;
    typedef struct packed {
        logic        rd;
        logic [13:0] addr;
        logic [3:0]  din;
    } req_t;

    state_t      state, state_nx;
    kind_t       kind, kind_nx;
    req_t        cur, cur_nx, cpu_req;
    logic [7:0]  addr_nx;
    logic        vid_pend, cpu_pend, armed, ref_pend;
    logic [13:0] vid_addr;
    logic [7:0]  ref_row;
    logic        grant_vid, grant_ref, grant_cpu, done;

    assign grant_vid = i_CEN && state == S_IDLE && vid_pend;
    assign grant_ref = i_CEN && state == S_IDLE && !vid_pend && ref_pend;
    assign grant_cpu = i_CEN && state == S_IDLE && !vid_pend && !ref_pend && cpu_pend;
    assign done      = i_CEN && state == S_LATCH;

    always_comb begin
        state_nx = state;
        kind_nx  = kind;
        cur_nx   = cur;
        addr_nx  = o_ADDR;
        case (state)
            S_IDLE: begin
                if (grant_vid) begin
                    kind_nx = K_VID;
                    cur_nx  = '{rd: 1'b1, addr: vid_addr, din: 4'h0};
                end else if (grant_ref) begin
                    kind_nx = K_REF;
                    cur_nx  = '{rd: 1'b1, addr: {6'h00, ref_row}, din: 4'h0};
                end else if (grant_cpu) begin
                    kind_nx = K_CPU;
                    cur_nx  = cpu_req;
                end
                if (grant_vid || grant_ref || grant_cpu) begin
                    state_nx = S_ROW;
                    addr_nx  = cur_nx.addr[7:0];
                end
            end
            S_ROW: begin
                // refresh is RAS-only: skip straight to precharge
                if (kind == K_REF) state_nx = S_PRE;
                else begin
                    state_nx = S_COL;
                    addr_nx  = {1'b0, cur.addr[13:8], 1'b0};
                end
            end
            S_COL:   state_nx = S_DATA;
            S_DATA:  state_nx = S_LATCH;
            S_LATCH: state_nx = S_PRE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state      <= S_IDLE;
            kind       <= K_VID;
            cur        <= '0;
            o_ADDR     <= 8'h00;
            o_DRAM_DIN <= 4'h0;
        end else if (i_CEN) begin
            state  <= state_nx;
            kind   <= kind_nx;
            cur    <= cur_nx;
            o_ADDR <= addr_nx;
            if (state == S_COL && kind == K_CPU && !cur.rd) o_DRAM_DIN <= cur.din;
        end
    end

    assign o_RAS_n = !(state inside {S_ROW, S_COL, S_DATA, S_LATCH});
    assign o_CAS_n = !(state inside {S_COL, S_DATA, S_LATCH});
    assign o_RD_n  = !(state == S_DATA && cur.rd);
    assign o_WR_n  = !(state == S_DATA && !cur.rd);

    // Request capture runs every MCLK; a new request wins over a same-edge clear.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            vid_pend <= 1'b0;
            vid_addr <= '0;
            cpu_pend <= 1'b0;
            armed    <= 1'b0;
            cpu_req  <= '0;
        end else begin
            if (i_VID_REQ) begin
                vid_pend <= 1'b1;
                vid_addr <= i_VID_ADDR;
            end else if (grant_vid) begin
                vid_pend <= 1'b0;
            end
            if (!i_CPU_CS_n && armed) begin
                cpu_pend <= 1'b1;
                cpu_req  <= '{rd: i_CPU_RW, addr: i_CPU_ADDR, din: i_CPU_DIN};
            end else if (done && kind == K_CPU) begin
                cpu_pend <= 1'b0;
            end
            if (i_CPU_CS_n) armed <= 1'b1;
            else if (armed) armed <= 1'b0;
        end
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            o_VID_DATA  <= 4'h0;
            o_VID_VALID <= 1'b0;
            o_CPU_DOUT  <= 4'h0;
            o_DTACK_n   <= 1'b1;
        end else begin
            o_VID_VALID <= done && kind == K_VID;
            if (done && kind == K_VID) o_VID_DATA <= i_DRAM_DOUT;
            if (done && kind == K_CPU && cur.rd) o_CPU_DOUT <= i_DRAM_DOUT;
            // an abandoned access (CS already high) completes silently
            if (i_CPU_CS_n) o_DTACK_n <= 1'b1;
            else if (done && kind == K_CPU) o_DTACK_n <= 1'b0;
        end
    end

`ifdef CHARRAM_DRAM_REFRESH_EN
    logic [15:0] step_cnt;

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            step_cnt <= 16'h0000;
            ref_pend <= 1'b0;
            ref_row  <= 8'h00;
        end else if (i_CEN) begin
            if (step_cnt == 16'(REFRESH_INTERVAL - 1)) begin
                step_cnt <= 16'h0000;
                ref_pend <= 1'b1;
            end else begin
                step_cnt <= step_cnt + 16'h0001;
                if (grant_ref) ref_pend <= 1'b0;
            end
            if (state == S_ROW && kind == K_REF) ref_row <= ref_row + 8'h01;
        end
    end
`else
    // interval only matters when refresh is built in
    assign ref_pend = 1'b0 & (REFRESH_INTERVAL != 0);
    assign ref_row  = 8'h00;
`endif

endmodule

// File: doc/charram_dram_ctrl.md
Name: charram_dram_ctrl

Overview:
- Initiator-side sequencer for the 4416-style 16k×4 character-RAM DRAM.
- Arbitrates video-fetch and CPU access requests and converts each 14-bit linear address into the multiplexed row/column phases: /RAS, /CAS, 8-bit DRAM address, /WR and /RD strobes.
- Returns read data to the requester and generates the CPU /DTACK.
- Sits between the CPU bus glue / character-fetch logic and the charram DRAM instance.

Parameters:
- REFRESH_INTERVAL, 64, number of enabled steps between refresh requests (used only with the optional feature).

Ports:
- i_MCLK  in  1  master clock; all state changes on its rising edge.
- i_RST_n  in  1  asynchronous active-low reset.
- i_CEN  in  1  step enable; the sequencer advances only on i_MCLK edges where i_CEN=1.
- i_VID_REQ  in  1  one-MCLK pulse requesting a video read.
- i_VID_ADDR  in  14  video read address, sampled with i_VID_REQ.
- o_VID_DATA  out  4  last video read data.
- o_VID_VALID  out  1  one-MCLK pulse when o_VID_DATA updates.
- i_CPU_CS_n  in  1  CPU access request, active low, level.
- i_CPU_RW  in  1  1=read, 0=write; sampled with the request.
- i_CPU_ADDR  in  14  CPU address.
- i_CPU_DIN  in  4  CPU write data.
- o_CPU_DOUT  out  4  CPU read data; held until the next CPU read completes.
- o_DTACK_n  out  1  CPU acknowledge, active low.
- o_ADDR  out  8  multiplexed DRAM address.
- o_RAS_n  out  1  row strobe.
- o_CAS_n  out  1  column strobe.
- o_WR_n  out  1  write strobe.
- o_RD_n  out  1  read strobe.
- o_DRAM_DIN  out  4  write data to DRAM.
- i_DRAM_DOUT  in  4  read data from DRAM.

Behaviour:
- Reset values (asynchronous, immediate, including mid-cycle):
  - o_RAS_n, o_CAS_n, o_WR_n, o_RD_n, o_DTACK_n = 1.
  - o_ADDR = 0; o_VID_DATA, o_CPU_DOUT, o_DRAM_DIN = 0; o_VID_VALID = 0.
  - State = IDLE; video pending, CPU pending and armed flags cleared.
- Address mapping:
  - Row phase: o_ADDR = A[7:0].
  - Column phase: o_ADDR = {1'b0, A[13:8], 1'b0}.
- Request capture (on any MCLK, independent of i_CEN):
  - i_VID_REQ sets video-pending and latches i_VID_ADDR. A new request while one is pending overwrites the pending address.
  - CPU pending is set when i_CPU_CS_n=0 and armed=1. Setting it clears armed and latches i_CPU_RW, i_CPU_ADDR, i_CPU_DIN.
  - Armed is set whenever i_CPU_CS_n=1. Exactly one access is performed per CS assertion.
- Steps below consume one enabled step each:
  - IDLE: RAS_n=CAS_n=1. Grant priority is video > refresh (optional) > CPU. With nothing pending, stay in IDLE. On a grant: drive the row address and go to ROW.
  - ROW: RAS_n=0, CAS_n=1, row address. Go to COL.
  - COL: RAS_n=0, CAS_n=0, column address. Go to DATA.
  - DATA: RAS_n=0, CAS_n=0. Assert RD_n=0 for reads or WR_n=0 for writes for the whole state. o_DRAM_DIN = latched data. Go to LATCH.
  - LATCH: strobes as in COL, RD_n/WR_n=1. On the leaving edge:
    - Video read: o_VID_DATA ← i_DRAM_DOUT and o_VID_VALID=1 for one MCLK.
    - CPU read: o_CPU_DOUT ← i_DRAM_DOUT.
    - Any CPU access: o_DTACK_n=0, and the corresponding pending flag clears.
    - Go to PRE.
  - PRE: RAS_n=CAS_n=1. Go to IDLE.
- Latency: a grant-to-completion cycle is 5 enabled steps (ROW through PRE), plus one IDLE step when a request is already pending.
- /DTACK: o_DTACK_n stays low until i_CPU_CS_n=1, then returns to 1 on the next MCLK. If CS deasserts before completion, the access still finishes, but /DTACK is not asserted.
- Simultaneous events:
  - Video and CPU pending together: video is served first; CPU is served in the next IDLE.
  - A video request arriving during a video cycle is queued as pending.
- With i_CEN held at 0, all outputs hold except request capture and /DTACK release.

Optional Feature:
- Macro: CHARRAM_DRAM_REFRESH_EN.
- Defined:
  - A 16-bit step counter raises refresh-pending every REFRESH_INTERVAL enabled steps.
  - The granted refresh performs a RAS-only cycle: IDLE → ROW (o_ADDR = 8-bit refresh row counter, RAS_n=0, CAS_n=1) → PRE → IDLE.
  - The row counter increments by 1 after each refresh and wraps 8'hFF→8'h00.
  - Refresh-pending is not cleared by a video grant; the refresh waits.
- Undefined: no counter, no refresh cycles, and REFRESH_INTERVAL is ignored.

Test Plan:
- CPU write 14'h2A5C, data 4'hB, i_CEN=1 → ROW o_ADDR=8'h5C; COL/DATA o_ADDR=8'h54 with WR_n=0 for one step and o_DRAM_DIN=4'hB; o_DTACK_n low after LATCH.
- CPU read of 14'h2A5C after the write → o_CPU_DOUT=4'hB when o_DTACK_n falls. /DTACK releases one MCLK after CS_n=1. Holding CS_n low produces no second access.
- i_VID_REQ addr 14'h0001 asserted on the same MCLK as a CPU read of 14'h3FFF → video cycle first (o_VID_VALID pulse), then the CPU cycle (row 8'hFF, column 8'h7E).
- i_CEN=1 on every 3rd MCLK → each state lasts exactly 3 MCLK and o_VID_VALID is still one MCLK wide.
- Assert i_RST_n=0 during DATA of a write → all strobes return to 1 immediately, no /DTACK, and the sequencer restarts in IDLE with no pending requests.
- With CHARRAM_DRAM_REFRESH_EN and REFRESH_INTERVAL=8, idle → RAS-only cycles with o_ADDR 8'h00, 8'h01, ..., no CAS_n=0. A refresh pending with a video request → video is served first.
